core_idecode_q: RTL and testbench



---
 rtl/core_idecode_q_pkg.sv | 32 +++
 rtl/core_idecode_q_if.sv | 31 +++
 rtl/core_idecode_comb.sv | 109 ++++++++++
 rtl/core_idecode_q.sv | 118 +++++++++++
 tb/tb_core_idecode_q.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/core_idecode_q_pkg.sv
// Shared constants for the buffered RV32I decode stage: opcodes, ID_CTRL bit map, immediate filler.
package core_idecode_q_pkg;
  localparam int CTRL_W      = 13;
  localparam int C_ISIMM     = 0;
  localparam int C_ISALU     = 1;
  localparam int C_ISBRANCH  = 2;
  localparam int C_ISLOAD    = 3;
  localparam int C_ISSTORE   = 4;
  localparam int C_AWVALID   = 5;
  localparam int C_REG1_RD   = 6;
  localparam int C_REG2_RD   = 7;
  localparam int C_ISJAL     = 8;
  localparam int C_ISJALR    = 9;
  localparam int C_ISLUI     = 10;
  localparam int C_ISAUIPC   = 11;
  localparam int C_ISMULDIV  = 12;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [31:0] IMM_DEFAULT = 32'hDEADBEEF;

  typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/core_idecode_q_if.sv
// Fetch-side and decode-side handshake bundle of core_idecode_q, plus flush.
interface core_idecode_q_if #(parameter int PC_W = 32);
  import core_idecode_q_pkg::*;
  logic            FLUSH;
  logic            IF_VALID;
  logic            IF_READY;
  logic [31:0]     IF_INSTR;
  logic [PC_W-1:0] IF_PC;
  logic            ID_VALID;
  logic            ID_READY;
  logic [PC_W-1:0] ID_PC;
  ctrl_t           ID_CTRL;
  logic            ID_ILLEGAL;
  logic [31:0]     IMM_DEC;
  logic [2:0]      FUNCT3;
  logic [6:0]      FUNCT7;
  logic [4:0]      REG_ARADDR1;
  logic [4:0]      REG_ARADDR2;
  logic [4:0]      REG_AWADDR;

  modport slave (
    input  FLUSH, IF_VALID, IF_INSTR, IF_PC, ID_READY,
    output IF_READY, ID_VALID, ID_PC, ID_CTRL, ID_ILLEGAL, IMM_DEC,
           FUNCT3, FUNCT7, REG_ARADDR1, REG_ARADDR2, REG_AWADDR
  );
  modport master (
    output FLUSH, IF_VALID, IF_INSTR, IF_PC, ID_READY,
    input  IF_READY, ID_VALID, ID_PC, ID_CTRL, ID_ILLEGAL, IMM_DEC,
           FUNCT3, FUNCT7, REG_ARADDR1, REG_ARADDR2, REG_AWADDR
  );
endinterface

// File: rtl/core_idecode_comb.sv
// Combinational RV32I word decoder; RV32M_EN enables funct7=0x01 (mul/div) decode.
module core_idecode_comb
  import core_idecode_q_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);
  ctrl_t      ctrl;
  logic       ill;
  logic       rd_nz;
  logic [2:0] f3;
  logic [6:0] f7;

  assign f3       = instr_i[14:12];
  assign f7       = instr_i[31:25];
  assign rd_nz    = |instr_i[11:7];
  assign funct3_o = f3;
  assign funct7_o = f7;
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign rd_o     = instr_i[11:7];

  always_comb begin
    ctrl  = '0;
    ill   = 1'b0;
    imm_o = IMM_DEFAULT;
    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (instr_i[6:0])
        OP_R: begin
          ctrl[C_ISALU]   = 1'b1;
          ctrl[C_REG1_RD] = 1'b1;
          ctrl[C_REG2_RD] = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          if (f7 == 7'h00) ill = 1'b0;
          else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ill = 1'b0;
`ifdef RV32M_EN
          else if (f7 == 7'h01) ctrl[C_ISMULDIV] = 1'b1;
`endif
          else ill = 1'b1;
        end
        OP_IMM: begin
          ctrl[C_ISIMM]   = 1'b1;
          ctrl[C_ISALU]   = 1'b1;
          ctrl[C_REG1_RD] = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
          if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
          if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        end
        OP_LOAD: begin
          ctrl[C_ISLOAD]  = 1'b1;
          ctrl[C_ISIMM]   = 1'b1;
          ctrl[C_REG1_RD] = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
          ill   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        OP_STORE: begin
          ctrl[C_ISSTORE] = 1'b1;
          ctrl[C_ISIMM]   = 1'b1;
          ctrl[C_REG1_RD] = 1'b1;
          ctrl[C_REG2_RD] = 1'b1;
          imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          ill   = f3 > 3'd2;
        end
        OP_BRANCH: begin
          ctrl[C_ISBRANCH] = 1'b1;
          ctrl[C_REG1_RD]  = 1'b1;
          ctrl[C_REG2_RD]  = 1'b1;
          imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
          ill   = (f3 == 3'd2) || (f3 == 3'd3);
        end
        OP_JAL: begin
          ctrl[C_ISJAL]   = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        end
        OP_JALR: begin
          ctrl[C_ISJALR]  = 1'b1;
          ctrl[C_ISIMM]   = 1'b1;
          ctrl[C_REG1_RD] = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
          ill   = f3 != 3'd0;
        end
        OP_LUI, OP_AUIPC: begin
          ctrl[C_ISLUI]   = instr_i[5];
          ctrl[C_ISAUIPC] = ~instr_i[5];
          ctrl[C_ISIMM]   = 1'b1;
          ctrl[C_AWVALID] = rd_nz;
          imm_o = {instr_i[31:12], 12'h000};
        end
        OP_FENCE: ill = 1'b0;
        default:  ill = 1'b1;
      endcase
    end
    illegal_o = ill;
    ctrl_o    = ill ? '0 : ctrl;
  end
endmodule

// File: rtl/core_idecode_q.sv
// DEPTH-entry instruction queue feeding one registered decode slot; empty queue bypasses fetch into the slot.
module core_idecode_q
  import core_idecode_q_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  core_idecode_q_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic            push, pop, byp, qpush, slot_ld, q_empty;
  logic [31:0]     src_instr;
  logic [PC_W-1:0] src_pc;

  ctrl_t           dec_ctrl, ctrl_q;
  logic            dec_ill, ill_q;
  logic [31:0]     dec_imm, imm_q;
  logic [2:0]      dec_f3, f3_q;
  logic [6:0]      dec_f7, f7_q;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd, rs1_q, rs2_q, rd_q;
  logic [PC_W-1:0] pc_q;

  assign bus.IF_READY = (cnt_q < CW'(DEPTH)) & ~RST;

  always_comb begin
    push      = bus.IF_VALID & bus.IF_READY;
    q_empty   = (cnt_q == '0);
    slot_ld   = ~vld_q | bus.ID_READY;
    pop       = slot_ld & ~q_empty;
    byp       = slot_ld & q_empty & push;
    qpush     = push & ~byp;
    src_instr = q_empty ? bus.IF_INSTR : mem_instr[rptr_q];
    src_pc    = q_empty ? bus.IF_PC : mem_pc[rptr_q];
    wptr_d    = wptr_q + AW'(qpush);
    rptr_d    = rptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(qpush) - CW'(pop);
    vld_d     = slot_ld ? (pop | byp) : vld_q;
  end

  core_idecode_comb u_dec (
    .instr_i   (src_instr),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_ill),
    .imm_o     (dec_imm),
    .funct3_o  (dec_f3),
    .funct7_o  (dec_f7),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .rd_o      (dec_rd)
  );

  always_ff @(posedge CLK) begin
    if (qpush) begin
      mem_instr[wptr_q] <= bus.IF_INSTR;
      mem_pc[wptr_q]    <= bus.IF_PC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      pc_q   <= '0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
      imm_q  <= '0;
      f3_q   <= '0;
      f7_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (bus.FLUSH) begin
      // Slot fields are left as-is; ID_VALID low makes them don't-care.
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      if (pop | byp) begin
        pc_q   <= src_pc;
        ctrl_q <= dec_ctrl;
        ill_q  <= dec_ill;
        imm_q  <= dec_imm;
        f3_q   <= dec_f3;
        f7_q   <= dec_f7;
        rs1_q  <= dec_rs1;
        rs2_q  <= dec_rs2;
        rd_q   <= dec_rd;
      end
    end
  end

  assign bus.ID_VALID    = vld_q;
  assign bus.ID_PC       = pc_q;
  assign bus.ID_CTRL     = ctrl_q;
  assign bus.ID_ILLEGAL  = ill_q;
  assign bus.IMM_DEC     = imm_q;
  assign bus.FUNCT3      = f3_q;
  assign bus.FUNCT7      = f7_q;
  assign bus.REG_ARADDR1 = rs1_q;
  assign bus.REG_ARADDR2 = rs2_q;
  assign bus.REG_AWADDR  = rd_q;
endmodule

// File: tb/tb_core_idecode_q.sv
// Scoreboard bench for core_idecode_q: stimulus pushes expectations, a negedge monitor compares the slot.
module tb_core_idecode_q;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_idecode_q_if #(.PC_W(32)) bus ();
  core_idecode_q #(.DEPTH(2), .PC_W(32)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [12:0] ctrl;
    logic [12:0] mask;
    logic        ill;
    logic [31:0] imm;
    logic        imm_chk;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_n   = 32'h100;

  localparam logic [12:0] ALL   = 13'h1FFF;
  localparam logic [12:0] NOIMM = 13'h1FFE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the slot is valid it must match the oldest expectation; pop on transfer.
  always @(negedge clk) begin
    if (!rst && bus.ID_VALID) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_pc", bus.ID_PC, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sbq[0];
        chk("out_pc", bus.ID_PC, e.pc);
        chk("out_illegal", {31'd0, bus.ID_ILLEGAL}, {31'd0, e.ill});
        chk("out_ctrl", {19'd0, bus.ID_CTRL & e.mask}, {19'd0, e.ctrl});
        if (e.imm_chk) chk("out_imm", bus.IMM_DEC, e.imm);
        chk("out_fields", {bus.FUNCT7, bus.FUNCT3, bus.REG_ARADDR1, bus.REG_ARADDR2, bus.REG_AWADDR},
            {e.instr[31:25], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[11:7]});
        if (bus.ID_READY) void'(sbq.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [12:0] ctrl, input logic [12:0] mask,
                      input logic ill, input logic [31:0] imm, input logic imm_chk);
    exp_t e;
    int   n;
    bus.IF_VALID = 1'b1;
    bus.IF_INSTR = instr;
    bus.IF_PC    = pc_n;
    n = 0;
    while (!bus.IF_READY && n < 20) begin
      tick();
      n++;
    end
    if (!bus.IF_READY) chk("send_timeout", 32'd0, 32'd1);
    e.pc = pc_n; e.instr = instr; e.ctrl = ctrl; e.mask = mask;
    e.ill = ill; e.imm = imm; e.imm_chk = imm_chk;
    sbq.push_back(e);
    pc_n = pc_n + 4;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0; bus.IF_INSTR = '0; bus.IF_PC = '0; bus.ID_READY = 1'b0;
    tick(); tick();
    chk("rst_if_ready", {31'd0, bus.IF_READY}, 32'd0);
    chk("rst_id_valid", {31'd0, bus.ID_VALID}, 32'd0);
    chk("rst_ctrl_ill", {18'd0, bus.ID_CTRL, bus.ID_ILLEGAL}, 32'd0);
    chk("rst_imm", bus.IMM_DEC, 32'd0);
    chk("rst_pc", bus.ID_PC, 32'd0);
    chk("rst_fields", {bus.FUNCT7, bus.FUNCT3, bus.REG_ARADDR1, bus.REG_ARADDR2, bus.REG_AWADDR}, 32'd0);
    rst = 1'b0;
    tick();
    chk("if_ready_after_rst", {31'd0, bus.IF_READY}, 32'd1);

    // addi x1,x0,5 with one-cycle latency
    bus.ID_READY = 1'b1;
    send(32'h00500093, 13'h063, ALL, 1'b0, 32'd5, 1'b1);
    bus.IF_VALID = 1'b0;
    chk("latency_valid", {31'd0, bus.ID_VALID}, 32'd1);
    chk("addi_awaddr", {27'd0, bus.REG_AWADDR}, 32'd1);
    drain();

    // back-to-back stream of directed vectors
    send(32'hFE208EE3, 13'h0C4, NOIMM, 1'b0, 32'hFFFFFFFC, 1'b1); // beq x1,x2,-4
    send(32'h402081B3, 13'h0E2, ALL,   1'b0, 32'hDEADBEEF, 1'b1); // sub
    send(32'h008000EF, 13'h120, NOIMM, 1'b0, 32'd8,        1'b1); // jal x1,8
    send(32'h123452B7, 13'h420, NOIMM, 1'b0, 32'h12345000, 1'b1); // lui
    send(32'h0020A223, 13'h0D0, NOIMM, 1'b0, 32'd4,        1'b1); // sw
    send(32'h00008067, 13'h240, NOIMM, 1'b0, 32'd0,        1'b1); // jalr x0
    send(32'h4020D1B3, 13'h0E2, ALL,   1'b0, 32'hDEADBEEF, 1'b1); // sra
    send(32'h0000000F, 13'h000, ALL,   1'b0, 32'd0,        1'b0); // fence
    send(32'h0000B083, 13'h000, ALL,   1'b1, 32'd0,        1'b0); // load f3=3
    send(32'h40109093, 13'h000, ALL,   1'b1, 32'd0,        1'b0); // slli f7=0x20
    send(32'h0020A063, 13'h000, ALL,   1'b1, 32'd0,        1'b0); // branch f3=2
`ifdef RV32M_EN
    send(32'h022080B3, 13'h10E2, ALL,  1'b0, 32'hDEADBEEF, 1'b1); // mul
`else
    send(32'h022080B3, 13'h0000, ALL,  1'b1, 32'd0,        1'b0); // mul
`endif
    bus.IF_VALID = 1'b0;
    drain();

    // capacity: DEPTH+1 in flight, then in-order drain with no bubbles
    bus.ID_READY = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] ins;
      ins = ((k + 1) << 20) | 32'h093;
      bus.IF_VALID = 1'b1;
      bus.IF_INSTR = ins;
      bus.IF_PC    = pc_n;
      if (bus.IF_READY) begin
        exp_t e;
        e.pc = pc_n; e.instr = ins; e.ctrl = 13'h063; e.mask = ALL;
        e.ill = 1'b0; e.imm = k + 1; e.imm_chk = 1'b1;
        sbq.push_back(e);
        acc++;
      end
      pc_n = pc_n + 4;
      tick();
    end
    bus.IF_VALID = 1'b0;
    chk("cap_accepted", acc, 3);
    chk("cap_if_ready_low", {31'd0, bus.IF_READY}, 32'd0);
    bus.ID_READY = 1'b1;
    tick(); tick(); tick();
    chk("cap_drained_3cyc", sbq.size(), 0);
    chk("cap_valid_after", {31'd0, bus.ID_VALID}, 32'd0);

    // flush with full queue and slot
    bus.ID_READY = 1'b0;
    send(32'h00100093, 13'h063, ALL, 1'b0, 32'd1, 1'b1);
    send(32'h00200093, 13'h063, ALL, 1'b0, 32'd2, 1'b1);
    send(32'h00300093, 13'h063, ALL, 1'b0, 32'd3, 1'b1);
    bus.IF_INSTR = 32'h00700093; bus.IF_PC = 32'hBAD0;
    bus.FLUSH = 1'b1;
    tick();
    sbq.delete();
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0;
    chk("flush_valid", {31'd0, bus.ID_VALID}, 32'd0);
    chk("flush_if_ready", {31'd0, bus.IF_READY}, 32'd1);

    // flush with an accepted fetch in the same cycle: it must be dropped
    send(32'h00400093, 13'h063, ALL, 1'b0, 32'd4, 1'b1);
    bus.IF_VALID = 1'b1; bus.IF_INSTR = 32'h00800093; bus.IF_PC = 32'hBAD4;
    bus.FLUSH = 1'b1;
    tick();
    sbq.delete();
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0;
    bus.ID_READY = 1'b1;
    chk("flush2_valid", {31'd0, bus.ID_VALID}, 32'd0);
    tick(); tick();
    chk("flush2_never_out", {31'd0, bus.ID_VALID}, 32'd0);

    // all-zero word is illegal but still presented; then reset mid-stream
    bus.ID_READY = 1'b0;
    send(32'h00000000, 13'h000, ALL, 1'b1, 32'd0, 1'b0);
    bus.IF_VALID = 1'b0;
    chk("zero_valid", {31'd0, bus.ID_VALID}, 32'd1);
    chk("zero_illegal", {31'd0, bus.ID_ILLEGAL}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    sbq.delete();
    chk("rst2_id_valid", {31'd0, bus.ID_VALID}, 32'd0);
    chk("rst2_if_ready", {31'd0, bus.IF_READY}, 32'd0);
    chk("rst2_ctrl_ill", {18'd0, bus.ID_CTRL, bus.ID_ILLEGAL}, 32'd0);
    chk("rst2_imm", bus.IMM_DEC, 32'd0);
    chk("rst2_pc", bus.ID_PC, 32'd0);
    chk("rst2_fields", {bus.FUNCT7, bus.FUNCT3, bus.REG_ARADDR1, bus.REG_ARADDR2, bus.REG_AWADDR}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst2_if_ready_after", {31'd0, bus.IF_READY}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
